checker_stat_collector: RTL and testbench
=========================================

// Module: checker_stat_collector
// PURPOSE
//  Downstream consumer of cpu_checker. Samples format_type/error_code every clk.
//  Counts completed trace records per type and counts error records.
//  Queues each error record in a small FIFO that a host/bench drains with a pop handshake.
//  Raises a sticky alarm after a run of consecutive bad records.
// PARAMETERS
//  CNT_W     16  width of each saturating record counter
//  DEPTH     8   error-FIFO entries; power of 2, >=2
//  ALARM_TH  3   consecutive error records that enter ALARM; 1..255
// PORTS
//  clk          in   1          single clock, all state updates on posedge
//  reset        in   1          synchronous, active-high
//  format_type  in   2          from cpu_checker: 0 none, 1 reg write, 2 mem write, 3 ignored
//  error_code   in   4          from cpu_checker; sampled only when format_type is 1 or 2
//  clr          in   1          sync soft clear (counters, FIFO, FSM); lower priority than reset
//  pop          in   1          consume FIFO head this cycle
//  reg_cnt      out  CNT_W      records with format_type==1
//  mem_cnt      out  CNT_W      records with format_type==2
//  err_cnt      out  CNT_W      records with error_code!=0
//  err_dout     out  6(+32)     FIFO head {format_type,error_code}(,timestamp); show-ahead
//  err_empty    out  1          FIFO empty
//  err_full     out  1          FIFO full
//  overflow     out  1          sticky: an error record was dropped while full
//  alarm_state  out  2          0 OK, 1 WARN, 2 ALARM
// BEHAVIOUR
//  - Reset or clr: all counters 0; FIFO emptied (err_empty=1, err_full=0); err_dout=0.
//    Also overflow=0, alarm_state=OK. Reset wins if both are asserted.
//  - Record event: a cycle with format_type in {1,2}. Each cycle is one event; there is no edge detect.
//  - Counters update 1 cycle after the event and saturate at all-ones; none wrap.
//  - Error event: a record event with error_code!=0. Pushes {format_type,error_code};
//    the entry is visible on err_dout the next cycle if the FIFO was empty.
//  - error_code with format_type 0/3: no count, no push, FSM unaffected.
//  - pop while empty: ignored. Push while full and no pop: entry dropped, overflow<=1.
//  - Push+pop same cycle: when full, both take effect (count unchanged).
//    When empty, only the push takes effect; there is no bypass.
//  - err_dout is valid only while !err_empty and holds its last value otherwise.
//  - Pointers are log2(DEPTH) bits plus a wrap bit; full = same index with the wrap bit differing.
//  - FSM, 8-bit streak counter of consecutive error events:
//      OK -> WARN on an error event (streak=1)
//      WARN -> OK on a clean record event (streak=0)
//      WARN -> ALARM when streak reaches ALARM_TH
//      ALARM is sticky until clr/reset; the streak saturates at 255
//      Non-record cycles change neither the streak nor the state
//  - ALARM_TH==1: the first error event goes OK -> ALARM directly.
// CONFIGURATION
//  STAT_TIMESTAMP_EN defined:
//    - a 32-bit free-running cycle counter (0 at reset/clr, wraps) is stored with each entry
//    - err_dout is 38 bits {ts,format_type,error_code}; ts is the counter value in the event cycle
//  STAT_TIMESTAMP_EN undefined: no counter; err_dout is 6 bits.
// TESTING
//  1 reset 2 cycles then idle 5 -> all counters 0, err_empty=1, alarm_state=0, overflow=0
//  2 format_type=1,err=0 for 1 cycle, then format_type=2,err=0 for 1 cycle
//    -> reg_cnt=1, mem_cnt=1, err_cnt=0, FIFO stays empty
//  3 three error events ft=1/err=4'h2 with idle cycles between, ALARM_TH=3
//    -> alarm_state 1,1,2; err_cnt=3; pop x3 yields 6'h12 three times, then err_empty=1
//  4 DEPTH+1 error events ft=2/err=4'h8, no pop
//    -> err_full=1, overflow=1, err_cnt=DEPTH+1; DEPTH pops drain exactly DEPTH entries of 6'h28
//  5 FIFO full, push+pop same cycle -> err_full stays 1, overflow stays 0, head advances
//    FIFO empty, push+pop same cycle -> entry retained, err_empty=0
//  6 in ALARM, assert clr 1 cycle -> alarm_state=0, counters 0, err_empty=1
//    With STAT_TIMESTAMP_EN, ts of the first entry after clr equals the cycles elapsed since clr

Source files
------------

// File: rtl/checker_stat_if.sv
// Record/FIFO bus between cpu_checker, checker_stat_collector and the host that drains errors.
// Width of err_dout follows STAT_TIMESTAMP_EN (38 bits with timestamp, 6 bits without).
interface checker_stat_if;
`ifdef STAT_TIMESTAMP_EN
    localparam int DOUT_W = 38;
`else
    localparam int DOUT_W = 6;
`endif

    logic [1:0]        format_type;
    logic [3:0]        error_code;
    logic              pop;
    logic [DOUT_W-1:0] err_dout;
    logic              err_empty;
    logic              err_full;

    modport master (
        output format_type, error_code, pop,
        input  err_dout, err_empty, err_full
    );

    modport slave (
        input  format_type, error_code, pop,
        output err_dout, err_empty, err_full
    );
endinterface

// File: rtl/checker_stat_collector.sv
// Per-type record counters, error-record FIFO (show-ahead) and consecutive-error alarm FSM.
// Optional feature macro STAT_TIMESTAMP_EN adds a 32-bit cycle timestamp to each FIFO entry.
module checker_stat_collector #(
    parameter int CNT_W    = 16,
    parameter int DEPTH    = 8,
    parameter int ALARM_TH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    checker_stat_if.slave    bus,
    output logic [CNT_W-1:0] reg_cnt,
    output logic [CNT_W-1:0] mem_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             overflow,
    output logic [1:0]       alarm_state
);
    localparam int AW = $clog2(DEPTH);
`ifdef STAT_TIMESTAMP_EN
    localparam int DOUT_W = 38;
`else
    localparam int DOUT_W = 6;
`endif
    localparam logic [7:0] ALARM_TH_V = 8'(ALARM_TH);

    typedef enum logic [1:0] {ST_OK = 2'd0, ST_WARN = 2'd1, ST_ALARM = 2'd2} state_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc_streak(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    logic [DOUT_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr_p1, rd_ptr_p1;
    logic [AW:0]       wr_nxt_p0, rd_nxt_p0;
    logic [DOUT_W-1:0] dout_p1, din_p0, head_nxt_p0;
    logic [7:0]        streak_p1, streak_d;
    state_t            state_p1, state_d;
    logic              rec_ev_p0, err_ev_p0, empty_p0, full_p0;
    logic              pop_ok_p0, push_ok_p0, drop_p0, dout_load_p0;
`ifdef STAT_TIMESTAMP_EN
    logic [31:0]       ts_p1;
`endif

    // Stage p0: classify the sampled record and resolve the FIFO handshake
    assign rec_ev_p0  = (bus.format_type == 2'd1) || (bus.format_type == 2'd2);
    assign err_ev_p0  = rec_ev_p0 && (bus.error_code != 4'd0);
    assign empty_p0   = (wr_ptr_p1 == rd_ptr_p1);
    assign full_p0    = (wr_ptr_p1[AW-1:0] == rd_ptr_p1[AW-1:0]) && (wr_ptr_p1[AW] != rd_ptr_p1[AW]);
    assign pop_ok_p0  = bus.pop && !empty_p0;
    assign push_ok_p0 = err_ev_p0 && (!full_p0 || bus.pop);
    assign drop_p0    = err_ev_p0 && full_p0 && !bus.pop;
    assign rd_nxt_p0  = rd_ptr_p1 + {{AW{1'b0}}, pop_ok_p0};
    assign wr_nxt_p0  = wr_ptr_p1 + {{AW{1'b0}}, push_ok_p0};
`ifdef STAT_TIMESTAMP_EN
    assign din_p0     = {ts_p1, bus.format_type, bus.error_code};
`else
    assign din_p0     = {bus.format_type, bus.error_code};
`endif

    // The new head is the incoming entry when it lands at the head slot, else already stored
    assign head_nxt_p0  = (push_ok_p0 && (rd_nxt_p0 == wr_ptr_p1)) ? din_p0 : mem[rd_nxt_p0[AW-1:0]];
    assign dout_load_p0 = (push_ok_p0 || pop_ok_p0) && (rd_nxt_p0 != wr_nxt_p0);

    always_comb begin
        state_d  = state_p1;
        streak_d = streak_p1;
        if (err_ev_p0) begin
            streak_d = sat_inc_streak(streak_p1);
            if (state_p1 != ST_ALARM)
                state_d = (streak_d >= ALARM_TH_V) ? ST_ALARM : ST_WARN;
        end else if (rec_ev_p0) begin
            streak_d = 8'd0;
            if (state_p1 == ST_WARN)
                state_d = ST_OK;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_p0)
            mem[wr_ptr_p1[AW-1:0]] <= din_p0;
    end

    // Stage p1: registered counters, pointers, head and FSM state
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            reg_cnt   <= '0;
            mem_cnt   <= '0;
            err_cnt   <= '0;
            overflow  <= 1'b0;
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            dout_p1   <= '0;
            state_p1  <= ST_OK;
            streak_p1 <= 8'd0;
`ifdef STAT_TIMESTAMP_EN
            ts_p1     <= 32'd0;
`endif
        end else begin
            if (bus.format_type == 2'd1) reg_cnt <= sat_inc_cnt(reg_cnt);
            if (bus.format_type == 2'd2) mem_cnt <= sat_inc_cnt(mem_cnt);
            if (err_ev_p0)               err_cnt <= sat_inc_cnt(err_cnt);
            if (drop_p0)                 overflow <= 1'b1;
            if (dout_load_p0)            dout_p1 <= head_nxt_p0;
            wr_ptr_p1 <= wr_nxt_p0;
            rd_ptr_p1 <= rd_nxt_p0;
            state_p1  <= state_d;
            streak_p1 <= streak_d;
`ifdef STAT_TIMESTAMP_EN
            ts_p1     <= ts_p1 + 32'd1;
`endif
        end
    end

    assign bus.err_dout  = dout_p1;
    assign bus.err_empty = empty_p0;
    assign bus.err_full  = full_p0;
    assign alarm_state   = state_p1;
endmodule

// File: tb/tb_checker_stat_collector.sv
// Randomized and directed bench for checker_stat_collector against a queue-based reference model.
module tb_checker_stat_collector;
    localparam int CNT_W    = 5;
    localparam int DEPTH    = 8;
    localparam int ALARM_TH = 3;
    localparam int CMAX     = (1 << CNT_W) - 1;
`ifdef STAT_TIMESTAMP_EN
    localparam int DW = 38;
`else
    localparam int DW = 6;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] reg_cnt, mem_cnt, err_cnt;
    logic             overflow;
    logic [1:0]       alarm_state;

    checker_stat_if ifc ();

    checker_stat_collector #(.CNT_W(CNT_W), .DEPTH(DEPTH), .ALARM_TH(ALARM_TH)) dut (
        .clk(clk), .reset(reset), .clr(clr), .bus(ifc.slave),
        .reg_cnt(reg_cnt), .mem_cnt(mem_cnt), .err_cnt(err_cnt),
        .overflow(overflow), .alarm_state(alarm_state)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers and a queue of entries
    int          reg_m, mem_m, err_m, streak_m, state_m;
    bit          ovf_m, live_m;
    int unsigned ts_m;
    logic [DW-1:0] q_m[$];
    logic [DW-1:0] dout_m;

    always @(posedge clk) begin
        automatic logic [1:0] ft = ifc.format_type;
        automatic logic [3:0] ec = ifc.error_code;
        automatic bit rec = (ft == 2'd1) || (ft == 2'd2);
        automatic bit err = rec && (ec != 4'd0);
        automatic int s = q_m.size();
        automatic logic [DW-1:0] ent;
        if (reset || clr) begin
            reg_m = 0; mem_m = 0; err_m = 0; streak_m = 0; state_m = 0;
            ovf_m = 0; ts_m = 0; dout_m = '0; q_m.delete();
            live_m = 1;
        end else begin
`ifdef STAT_TIMESTAMP_EN
            ent = {ts_m, ft, ec};
`else
            ent = {ft, ec};
`endif
            if (ft == 2'd1 && reg_m < CMAX) reg_m++;
            if (ft == 2'd2 && mem_m < CMAX) mem_m++;
            if (err && err_m < CMAX) err_m++;
            if (ifc.pop && s > 0) void'(q_m.pop_front());
            if (err) begin
                if (s < DEPTH || ifc.pop) q_m.push_back(ent);
                else ovf_m = 1;
            end
            if (q_m.size() > 0) dout_m = q_m[0];
            if (err) begin
                if (streak_m < 255) streak_m++;
                if (state_m != 2) state_m = (streak_m >= ALARM_TH) ? 2 : 1;
            end else if (rec) begin
                streak_m = 0;
                if (state_m == 1) state_m = 0;
            end
            ts_m++;
        end
    end

    always @(negedge clk) begin
        if (live_m) begin
            check("reg_cnt", reg_cnt, reg_m);
            check("mem_cnt", mem_cnt, mem_m);
            check("err_cnt", err_cnt, err_m);
            check("err_empty", ifc.err_empty, q_m.size() == 0);
            check("err_full", ifc.err_full, q_m.size() == DEPTH);
            check("overflow", overflow, ovf_m);
            check("alarm_state", alarm_state, state_m);
            check("err_dout", ifc.err_dout, dout_m);
        end
    end

    task automatic cyc(input logic [1:0] ft, input logic [3:0] ec, input logic p,
                       input logic c, input logic r);
        ifc.format_type = ft;
        ifc.error_code  = ec;
        ifc.pop         = p;
        clr             = c;
        reset           = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifc.format_type = 2'd0;
        ifc.error_code  = 4'd0;
        ifc.pop         = 1'b0;

        // 1: reset then idle
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        check("t1_reg", reg_cnt, 0);
        check("t1_err", err_cnt, 0);
        check("t1_empty", ifc.err_empty, 1);
        check("t1_alarm", alarm_state, 0);
        check("t1_ovf", overflow, 0);

        // 2: one clean reg write, one clean mem write; ignored type with error code
        cyc(1, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0);
        cyc(3, 4'hF, 0, 0, 0);
        check("t2_reg", reg_cnt, 1);
        check("t2_mem", mem_cnt, 1);
        check("t2_err", err_cnt, 0);
        check("t2_empty", ifc.err_empty, 1);

        // 3: three spaced error events walk OK->WARN->WARN->ALARM
        cyc(1, 2, 0, 0, 0); check("t3_a1", alarm_state, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 2, 0, 0, 0); check("t3_a2", alarm_state, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 2, 0, 0, 0); check("t3_a3", alarm_state, 2);
        check("t3_err", err_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            check("t3_head", ifc.err_dout[5:0], 6'h12);
            cyc(0, 0, 1, 0, 0);
        end
        check("t3_empty", ifc.err_empty, 1);

        // WARN returns to OK on a clean record
        cyc(0, 0, 0, 1, 0);
        cyc(2, 1, 0, 0, 0); check("warn_set", alarm_state, 1);
        cyc(1, 0, 0, 0, 0); check("warn_clear", alarm_state, 0);

        // 4: DEPTH+1 errors without pop overflow the FIFO
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(2, 8, 0, 0, 0);
        check("t4_full", ifc.err_full, 1);
        check("t4_ovf", overflow, 1);
        check("t4_err", err_cnt, DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) begin
            check("t4_head", ifc.err_dout[5:0], 6'h28);
            cyc(0, 0, 1, 0, 0);
        end
        check("t4_empty", ifc.err_empty, 1);

        // 5: push+pop while full, then while empty
        cyc(0, 0, 0, 1, 0);
        for (int i = 1; i <= DEPTH; i++) cyc(1, 4'(i), 0, 0, 0);
        check("t5_full0", ifc.err_full, 1);
        check("t5_head0", ifc.err_dout[5:0], 6'h11);
        cyc(1, 9, 1, 0, 0);
        check("t5_full1", ifc.err_full, 1);
        check("t5_ovf", overflow, 0);
        check("t5_head1", ifc.err_dout[5:0], 6'h12);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0, 0);
        check("t5_drained", ifc.err_empty, 1);
        cyc(1, 3, 1, 0, 0);
        check("t5_kept", ifc.err_empty, 0);
        check("t5_head2", ifc.err_dout[5:0], 6'h13);

        // 6: clr out of ALARM
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(2, 5, 0, 0, 0);
        check("t6_alarm", alarm_state, 2);
        cyc(0, 0, 0, 1, 0);
        check("t6_alarm0", alarm_state, 0);
        check("t6_mem0", mem_cnt, 0);
        check("t6_err0", err_cnt, 0);
        check("t6_empty", ifc.err_empty, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 7, 0, 0, 0);
        check("t6_entry", ifc.err_dout[5:0], 6'h17);
`ifdef STAT_TIMESTAMP_EN
        check("t6_ts", ifc.err_dout[37:6], 32'd4);
`endif

        // Counter saturation
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < CMAX + 4; i++) cyc(1, 0, 0, 0, 0);
        check("sat_reg", reg_cnt, CMAX);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            automatic logic [3:0] ec = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            cyc(2'($urandom_range(0, 3)), ec, $urandom_range(0, 99) < 35,
                $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0);
        end
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
